// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg: shared state encoding and one-hot helper for the pulse decoder
package onehot_dec_pkg;
  localparam int MAX_CODE_W = 8;
  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
  function automatic logic [2**MAX_CODE_W-1:0] onehot(input logic [MAX_CODE_W-1:0] code);
    onehot = '0;
    onehot[code] = 1'b1;
  endfunction
endpackage

// File: rtl/onehot_dec_slot.sv
// onehot_dec_slot: one-entry pending code buffer with registered ready
module onehot_dec_slot #(
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [CODE_W-1:0] push_code,
  output logic [CODE_W-1:0] code,
  output logic              vld,
  output logic              rdy
);
  logic vld_nxt;
  assign vld_nxt = push || (vld && !pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      rdy  <= 1'b0;
      code <= '0;
    end else begin
      vld <= vld_nxt;
      rdy <= !vld_nxt;
      if (push) code <= push_code;
    end
  end
endmodule

// File: rtl/onehot_pulse_decoder.sv
// onehot_pulse_decoder: code-to-one-hot pulse generator with hold/gap timing; ONEHOT_DEC_HITCNT_EN adds hit_count/cnt_clr
module onehot_pulse_decoder
  import onehot_dec_pkg::*;
#(
  parameter int CODE_W   = 3,
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 1,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    in_code,
  output logic [2**CODE_W-1:0] out_line,
  output logic                 out_busy
`ifdef ONEHOT_DEC_HITCNT_EN
  ,
  output logic [CNT_W-1:0]     hit_count,
  input  logic                 cnt_clr
`endif
);
  localparam int LINES = 2**CODE_W;
  localparam int MX    = HOLD_CYC > GAP_CYC ? HOLD_CYC : GAP_CYC;
  localparam int CW    = $clog2(MX) + 1;
  localparam int GL    = GAP_CYC > 0 ? GAP_CYC - 1 : 0;
  state_t            state;
  logic [CW-1:0]     cnt;
  logic              acc, start, push, pop, hold_end, gap_end, pend_vld;
  logic [CODE_W-1:0] pend_code, code_sel;
  assign acc      = in_valid && in_ready;
  assign hold_end = state == HOLD && cnt == '0;
  assign gap_end  = state == GAP && cnt == '0;
  assign pop      = pend_vld && (state == IDLE || gap_end || (hold_end && GAP_CYC == 0));
  assign start    = pop || (acc && state == IDLE);
  assign push     = acc && state != IDLE;
  assign code_sel = pop ? pend_code : in_code;
  assign out_busy = state != IDLE || pend_vld;
  onehot_dec_slot #(.CODE_W(CODE_W)) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_code (in_code),
    .code      (pend_code),
    .vld       (pend_vld),
    .rdy       (in_ready)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      out_line <= '0;
    end else if (start) begin
      state    <= HOLD;
      cnt      <= CW'(HOLD_CYC - 1);
      out_line <= LINES'(onehot(MAX_CODE_W'(code_sel)));
    end else if (hold_end) begin
      state    <= GAP_CYC == 0 ? IDLE : GAP;
      cnt      <= CW'(GL);
      out_line <= '0;
    end else if (gap_end) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state != IDLE) begin
      cnt <= cnt - CW'(1);
    end
  end
`ifdef ONEHOT_DEC_HITCNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) hit_count <= '0;
    else if (acc && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// tb_onehot_pulse_decoder: directed bench with a remaining-cycles timeline model
module tb_onehot_pulse_decoder;
  localparam int H = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vin[2];
  logic       rdy[2];
  logic       busy[2];
  logic [2:0] cin[2];
  logic [7:0] line[2];
  logic [1:0] hit0, hit1;
  logic       clr = 1'b0;
  int         tests = 0, fails = 0;
  int         m_rem[2], m_cur[2], m_pc[2], m_ra;
  bit         m_pv[2], m_rdy[2], m_acc, m_idle, m_pv_old;
  bit         started = 1'b0;
  int         gapk[2] = '{1, 0};
  logic [7:0] seq2[6]  = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
  logic [7:0] seq3[10] = '{8'h08, 8'h08, 8'h08, 8'h08, 8'h00, 8'h40, 8'h40, 8'h40, 8'h40, 8'h00};
  logic [7:0] seq4[9]  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00};

  always #5 clk = ~clk;

  onehot_pulse_decoder #(.CODE_W(3), .HOLD_CYC(H), .GAP_CYC(1), .CNT_W(2)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_ready(rdy[0]), .in_code(cin[0]),
    .out_line(line[0]), .out_busy(busy[0])
`ifdef ONEHOT_DEC_HITCNT_EN
    , .hit_count(hit0), .cnt_clr(clr)
`endif
  );
  onehot_pulse_decoder #(.CODE_W(3), .HOLD_CYC(H), .GAP_CYC(0), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_ready(rdy[1]), .in_code(cin[1]),
    .out_line(line[1]), .out_busy(busy[1])
`ifdef ONEHOT_DEC_HITCNT_EN
    , .hit_count(hit1), .cnt_clr(1'b0)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_line(input int k);
    return m_rem[k] > gapk[k] ? 8'(1 << m_cur[k]) : 8'h00;
  endfunction

  // m_rem counts display cycles left in the current pulse plus its gap
  always @(posedge clk) begin
    started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_rem[k] = 0;
        m_pv[k]  = 1'b0;
        m_rdy[k] = 1'b0;
      end else begin
        m_acc    = vin[k] && m_rdy[k];
        m_idle   = m_rem[k] == 0;
        m_ra     = m_idle ? 0 : m_rem[k] - 1;
        m_pv_old = m_pv[k];
        if (m_ra == 0 && m_pv_old) begin
          m_cur[k] = m_pc[k];
          m_rem[k] = H + gapk[k];
          m_pv[k]  = 1'b0;
        end else if (m_ra == 0 && m_idle && m_acc) begin
          m_cur[k] = int'(cin[k]);
          m_rem[k] = H + gapk[k];
        end else begin
          m_rem[k] = m_ra;
        end
        if (m_acc && !m_idle) begin
          m_pv[k] = 1'b1;
          m_pc[k] = int'(cin[k]);
        end
        m_rdy[k] = !m_pv[k];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d line", k), line[k], exp_line(k));
        check($sformatf("u%0d ready", k), rdy[k], m_rdy[k]);
        check($sformatf("u%0d busy", k), busy[k], m_rem[k] > 0 || m_pv[k]);
        check($sformatf("u%0d onehot0", k), $onehot0(line[k]), 1);
      end
    end
  end

`ifdef ONEHOT_DEC_HITCNT_EN
  task automatic wait_rdy();
    for (int i = 0; i < 40 && !rdy[0]; i++) @(negedge clk);
    if (!rdy[0]) check("ready timeout", rdy[0], 1);
  endtask
`endif

  initial begin
    vin = '{1'b1, 1'b1};
    cin = '{3'd5, 3'd2};
    repeat (3) begin
      @(negedge clk);
      check("reset ready", rdy[0], 0);
      check("reset line", line[0], 0);
    end
    rst_n = 1'b1;
    vin = '{1'b0, 1'b0};
    @(negedge clk);
    check("no accept in reset", busy[0], 0);
    @(negedge clk);
    check("ready after reset", rdy[0], 1);
    vin[0] = 1'b1;
    cin[0] = 3'd5;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check($sformatf("single c%0d", i), line[0], seq2[i-1]);
      if (i == 1) vin[0] = 1'b0;
    end
    check("single idle", busy[0], 0);
    @(negedge clk);
    vin[0] = 1'b1;
    cin[0] = 3'd3;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check($sformatf("queue c%0d", i), line[0], seq3[i-1]);
      if (i == 1) vin[0] = 1'b0;
      if (i == 2) begin vin[0] = 1'b1; cin[0] = 3'd6; end
      if (i == 3) begin check("slot full ready", rdy[0], 0); cin[0] = 3'd7; end
      if (i == 5) vin[0] = 1'b0;
    end
    @(negedge clk);
    vin[1] = 1'b1;
    cin[1] = 3'd0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      check($sformatf("gap0 c%0d", i), line[1], seq4[i-1]);
      if (i == 1) cin[1] = 3'd7;
      if (i == 2) vin[1] = 1'b0;
    end
    @(negedge clk);
    vin[0] = 1'b1;
    cin[0] = 3'd2;
    @(negedge clk);
    check("rst pulse c1", line[0], 8'h04);
    cin[0] = 3'd4;
    @(negedge clk);
    check("rst pulse c2", line[0], 8'h04);
    vin[0] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid reset line", line[0], 0);
    check("mid reset busy", busy[0], 0);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("pending dropped", line[0], 0);
    end
`ifdef ONEHOT_DEC_HITCNT_EN
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("hit clr", hit0, 0);
    for (int n = 0; n < 5; n++) begin
      wait_rdy();
      vin[0] = 1'b1;
      cin[0] = 3'(n);
      @(negedge clk);
      vin[0] = 1'b0;
    end
    check("hit saturate", hit0, 3);
    wait_rdy();
    vin[0] = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    clr = 1'b0;
    check("hit clr wins", hit0, 0);
    repeat (30) @(negedge clk);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule
